// File: rtl/tpu_pkg.sv
// tpu_pkg: shared types and helpers for the tpu_core systolic engine.
//   state_t  - controller states (IDLE -> LOAD -> COMPUTE -> OUTPUT -> IDLE)
//   FN_W     - width used by the reduction helpers (accumulators are
//              sign-extended to FN_W before ReLU / saturation, so ACC_W <= 32)
//   addr_w() - operand-memory address width for an N x N engine
//   relu()   - clamp negative values to zero
//   sat8()   - saturate a signed value to the signed 8-bit range
// Optional feature macro used by tpu_core: TPU_WIDE_OUT_EN.
package tpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_OUTPUT  = 2'd3
    } state_t;

    localparam int FN_W = 32;

    // W occupies addresses 0..N*N-1, X occupies N*N..2*N*N-1.
    function automatic int addr_w(input int n);
        return $clog2(2 * n * n);
    endfunction

    function automatic logic signed [FN_W-1:0] relu(input logic signed [FN_W-1:0] v);
        return (v < 0) ? '0 : v;
    endfunction

    function automatic logic [7:0] sat8(input logic signed [FN_W-1:0] v);
        if (v > 127)
            return 8'h7f;
        else if (v < -128)
            return 8'h80;
        else
            return v[7:0];
    endfunction

endpackage

// File: rtl/tpu_pe.sv
// tpu_pe: one multiply-accumulate cell of the output-stationary array.
//   clk, rst_n   - clock, synchronous active-low reset
//   en           - perform the MAC and advance the pass-through registers
//   clr          - synchronous clear of accumulator and pass-through registers
//   x_in / x_out - X operand from the left, registered copy to the right
//   w_in / w_out - W operand from the top, registered copy downwards
//   acc          - running signed accumulator (wraps modulo 2^ACC_W)
module tpu_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] w_in,
    output logic signed [DATA_W-1:0] x_out,
    output logic signed [DATA_W-1:0] w_out,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;

    assign prod = x_in * w_in;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            x_out <= '0;
            w_out <= '0;
            acc   <= '0;
        end else if (en) begin
            x_out <= x_in;
            w_out <= w_in;
            // Signed cast sign-extends the full-width product.
            acc   <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/tpu_core.sv
// tpu_core: N x N output-stationary systolic matrix-multiply engine.
// Computes C = X*W (or X*W^T), optional ReLU, and streams C row-major.
//   clk, rst_n            - clock, synchronous active-low reset
//   load_en, in_data      - byte load: W row-major then X row-major
//   transpose, activation - W^T select / ReLU enable, latched at COMPUTE entry
//   out_data, out_valid   - result byte stream
//   out_ready             - consumer backpressure
//   done                  - one-cycle pulse after the final transfer
//   busy                  - high in COMPUTE and OUTPUT
//   dbg_state             - current controller state
// Handshake: a transfer happens on a rising edge where out_valid & out_ready;
// while out_valid is high and out_ready low, out_valid and out_data hold.
// Macro TPU_WIDE_OUT_EN: send each ReLU'd ACC_W result as ACC_W/8 bytes,
// LSB first, instead of one saturated byte.
module tpu_core
    import tpu_pkg::*;
#(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [DATA_W-1:0] in_data,
    input  logic              transpose,
    input  logic              activation,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done,
    output logic              busy,
    output state_t            dbg_state
);

    localparam int AW     = addr_w(N);
    localparam int NN     = N * N;
    localparam int MEM_D  = 2 * NN;
    localparam int STEP_W = 5;
    localparam int EW     = $clog2(NN);
`ifdef TPU_WIDE_OUT_EN
    localparam int BPE    = ACC_W / 8;
    localparam int BW     = (BPE > 1) ? $clog2(BPE) : 1;
`endif

    state_t                   state, state_next;
    logic [AW-1:0]            addr;
    logic [DATA_W-1:0]        mem [MEM_D];
    logic                     trans_q, act_q;
    logic [STEP_W-1:0]        step;
    logic [EW-1:0]            elem;
`ifdef TPU_WIDE_OUT_EN
    logic [BW-1:0]            byte_idx;
`endif
    logic                     load_fire, load_last, accept, last_xfer;
    logic signed [DATA_W-1:0] x_feed [N];
    logic signed [DATA_W-1:0] w_feed [N];
    logic signed [DATA_W-1:0] x_pass [N][N];
    logic signed [DATA_W-1:0] w_pass [N][N];
    logic signed [ACC_W-1:0]  acc_arr [NN];
    logic signed [ACC_W-1:0]  acc_sel;
    logic signed [FN_W-1:0]   res;

    assign dbg_state = state;

    // Next-state and handshake decode.
    always_comb begin
        state_next = state;
        load_fire  = 1'b0;
        load_last  = 1'b0;
        out_valid  = (state == ST_OUTPUT);
        busy       = (state == ST_COMPUTE) || (state == ST_OUTPUT);
        accept     = out_valid && out_ready;
`ifdef TPU_WIDE_OUT_EN
        last_xfer  = (elem == EW'(NN - 1)) && (byte_idx == BW'(BPE - 1));
`else
        last_xfer  = (elem == EW'(NN - 1));
`endif
        case (state)
            ST_IDLE, ST_LOAD: begin
                if (load_en) begin
                    load_fire = 1'b1;
                    if (addr == AW'(MEM_D - 1)) begin
                        load_last  = 1'b1;
                        state_next = ST_COMPUTE;
                    end else begin
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_COMPUTE: begin
                // Last MAC (PE(N-1,N-1), step 3N-3) lands on this edge.
                if (step == STEP_W'(3 * N - 3))
                    state_next = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (accept && last_xfer)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            addr     <= '0;
            trans_q  <= 1'b0;
            act_q    <= 1'b0;
            step     <= '0;
            elem     <= '0;
`ifdef TPU_WIDE_OUT_EN
            byte_idx <= '0;
`endif
            done     <= 1'b0;
            for (int k = 0; k < MEM_D; k++)
                mem[AW'(k)] <= '0;
        end else begin
            state <= state_next;
            done  <= (state == ST_OUTPUT) && accept && last_xfer;
            if (load_fire) begin
                mem[addr] <= in_data;
                addr      <= load_last ? '0 : addr + 1'b1;
            end
            if (load_last) begin
                trans_q  <= transpose;
                act_q    <= activation;
                step     <= '0;
                elem     <= '0;
`ifdef TPU_WIDE_OUT_EN
                byte_idx <= '0;
`endif
            end
            if (state == ST_COMPUTE)
                step <= step + 1'b1;
            if (accept) begin
`ifdef TPU_WIDE_OUT_EN
                if (byte_idx == BW'(BPE - 1)) begin
                    byte_idx <= '0;
                    elem     <= elem + 1'b1;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                end
`else
                elem <= elem + 1'b1;
`endif
            end
        end
    end

    // Skewed edge feed: row i of X and column j of W enter delayed by i / j
    // steps; the PE pass-through registers provide the remaining skew.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            int k;
            k         = int'(step) - i;
            x_feed[i] = '0;
            w_feed[i] = '0;
            if (state == ST_COMPUTE && k >= 0 && k < N) begin
                x_feed[i] = mem[AW'(NN + i * N + k)];
                w_feed[i] = trans_q ? mem[AW'(i * N + k)] : mem[AW'(k * N + i)];
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic signed [DATA_W-1:0] x_in_c, w_in_c;
            if (gj == 0) begin : g_xl
                assign x_in_c = x_feed[gi];
            end else begin : g_xi
                assign x_in_c = x_pass[gi][gj-1];
            end
            if (gi == 0) begin : g_wt
                assign w_in_c = w_feed[gj];
            end else begin : g_wi
                assign w_in_c = w_pass[gi-1][gj];
            end
            tpu_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (state == ST_COMPUTE),
                .clr   (load_last),
                .x_in  (x_in_c),
                .w_in  (w_in_c),
                .x_out (x_pass[gi][gj]),
                .w_out (w_pass[gi][gj]),
                .acc   (acc_arr[gi*N+gj])
            );
        end
    end

    // Output reduction: ReLU first, then saturate (or byte-slice when wide).
    always_comb begin
        acc_sel  = acc_arr[elem];
        res      = act_q ? relu(FN_W'(acc_sel)) : FN_W'(acc_sel);
        out_data = '0;
        if (state == ST_OUTPUT) begin
`ifdef TPU_WIDE_OUT_EN
            out_data = res[byte_idx*8 +: 8];
`else
            out_data = sat8(res);
`endif
        end
    end

endmodule

// File: tb/tb_tpu_core.sv
// tb_tpu_core: directed bench for tpu_core (N=2 instance plus an N=4 instance).
// Expected bytes come from a software matrix model pushed to exp_q at load time
// and popped on each accepted transfer. Honors TPU_WIDE_OUT_EN.
module tb_tpu_core;
    import tpu_pkg::*;

`ifdef TPU_WIDE_OUT_EN
    localparam int BPE = 2;
`else
    localparam int BPE = 1;
`endif

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, load_en, transpose, activation, out_ready, sel4;
    logic [7:0] in_data;
    logic [7:0] od2, od4;
    logic       ov2, ov4, dn2, dn4, bz2, bz4;
    state_t     st2, st4;
    logic       en2, en4;
    logic [7:0] out_data;
    logic       out_valid, done, busy;

    assign en2       = load_en & ~sel4;
    assign en4       = load_en & sel4;
    assign out_data  = sel4 ? od4 : od2;
    assign out_valid = sel4 ? ov4 : ov2;
    assign done      = sel4 ? dn4 : dn2;
    assign busy      = sel4 ? bz4 : bz2;

    tpu_core #(.N(2), .DATA_W(8), .ACC_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .load_en(en2), .in_data(in_data),
        .transpose(transpose), .activation(activation),
        .out_data(od2), .out_valid(ov2), .out_ready(out_ready),
        .done(dn2), .busy(bz2), .dbg_state(st2)
    );

    tpu_core #(.N(4), .DATA_W(8), .ACC_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .load_en(en4), .in_data(in_data),
        .transpose(transpose), .activation(activation),
        .out_data(od4), .out_valid(ov4), .out_ready(out_ready),
        .done(dn4), .busy(bz4), .dbg_state(st4)
    );

    // scoreboard
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_expected(input int n, input int w[64], input int x[64],
                                 input bit tr, input bit act);
        int c;
        logic signed [15:0] c16;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                c = 0;
                for (int k = 0; k < n; k++)
                    c += x[i*n+k] * (tr ? w[j*n+k] : w[k*n+j]);
                c16 = 16'(c);
                if (act && c16 < 0)
                    c16 = 16'sd0;
                if (BPE == 2) begin
                    exp_q.push_back(c16[7:0]);
                    exp_q.push_back(c16[15:8]);
                end else if (c16 > 16'sd127) begin
                    exp_q.push_back(8'h7f);
                end else if (c16 < -16'sd128) begin
                    exp_q.push_back(8'h80);
                end else begin
                    exp_q.push_back(c16[7:0]);
                end
            end
        end
    endtask

    // driver: load W then X, optionally with random load_en gaps
    task automatic load_job(input int n, input int w[64], input int x[64],
                            input bit tr, input bit act, input bit gaps);
        sel4 = (n == 4);
        push_expected(n, w, x, tr, act);
        transpose  = tr;
        activation = act;
        for (int a = 0; a < 2*n*n; a++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    load_en = 1'b0;
                    in_data = 8'($urandom_range(0, 255));
                end
            end
            @(negedge clk);
            load_en = 1'b1;
            in_data = (a < n*n) ? 8'(w[a]) : 8'(x[a-n*n]);
        end
    endtask

    // driver + monitor: wait for results, drain with optional random
    // backpressure, optionally abort with reset after abort_at transfers
    task automatic run_job(input int n, input bit rand_ready, input int abort_at);
        int         lat, got, cyc, xfers;
        logic [7:0] hold;
        bit         stalled;
        xfers     = n * n * BPE;
        lat       = 0;
        out_ready = 1'b1;
        do begin
            @(negedge clk);
            load_en = 1'b0;
            lat++;
            if (lat == 1) check("busy_compute", busy, 1);
        end while (!out_valid && lat < 100);
        // first negedge after the capture edge counts as 1
        check("latency", lat, 3*n - 1);
        got = 0; cyc = 0; stalled = 0; hold = '0;
        while (got < xfers && cyc < 1000) begin
            if (got == abort_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                check("abort_valid", out_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_data", out_data, 0);
                check("abort_state", st2, ST_IDLE);
                rst_n = 1'b1;
                exp_q.delete();
                return;
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    check("sb_empty", 32'(exp_q.size()), 1);
                else
                    check("data", out_data, exp_q.pop_front());
                got++;
            end else if (out_valid) begin
                hold    = out_data;
                stalled = 1'b1;
            end else begin
                check("valid_gap", out_valid, 1);
            end
            @(negedge clk);
            cyc++;
            if (stalled) begin
                check("stall_data", out_data, hold);
                check("stall_valid", out_valid, 1);
                stalled = 1'b0;
            end
        end
        check("xfer_count", got, xfers);
        check("done_pulse", done, 1);
        check("valid_low_after", out_valid, 0);
        check("busy_low_after", busy, 0);
        check("sb_drained", 32'(exp_q.size()), 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    int wa[64], xa[64], wm[64], wf[64], xf[64], wi[64], xr[64];

    initial begin
        rst_n = 1'b0; load_en = 1'b0; in_data = '0; transpose = 1'b0;
        activation = 1'b0; out_ready = 1'b1; sel4 = 1'b0;
        wa = '{default: 0}; xa = '{default: 0}; wm = '{default: 0};
        wf = '{default: 0}; xf = '{default: 0}; wi = '{default: 0};
        xr = '{default: 0};
        repeat (3) @(negedge clk);
        check("rst_valid", ov2, 0);
        check("rst_busy", bz2, 0);
        check("rst_done", dn2, 0);
        check("rst_data", od2, 0);
        check("rst_state", st2, ST_IDLE);
        check("rst_valid4", ov4, 0);
        rst_n = 1'b1;
        @(negedge clk);

        wa[0] = 1; wa[1] = 2; wa[2] = 3; wa[3] = 4;
        xa[0] = 5; xa[1] = 6; xa[2] = 7; xa[3] = 8;
        wm[0] = -1; wm[3] = -1;
        for (int k = 0; k < 4; k++) begin
            wf[k] = 127;
            xf[k] = 127;
        end

        // plain product, ready held high
        load_job(2, wa, xa, 0, 0, 0);
        run_job(2, 0, -1);
        // transposed weights
        load_job(2, wa, xa, 1, 0, 0);
        run_job(2, 0, -1);
        // negative results, without and with ReLU
        load_job(2, wm, xa, 0, 0, 0);
        run_job(2, 0, -1);
        load_job(2, wm, xa, 0, 1, 0);
        run_job(2, 0, -1);
        // saturation / wide-output boundary
        load_job(2, wf, xf, 0, 0, 0);
        run_job(2, 0, -1);
        // load gaps and random backpressure
        load_job(2, wa, xa, 0, 0, 1);
        run_job(2, 1, -1);
        load_job(2, wa, xa, 1, 1, 1);
        run_job(2, 1, -1);
        // reset mid-OUTPUT
        load_job(2, wa, xa, 0, 0, 0);
        run_job(2, 0, 1);

        // N=4, identity weights return X
        for (int k = 0; k < 16; k++) begin
            wi[k] = ((k / 4) == (k % 4)) ? 1 : 0;
            xr[k] = int'($urandom_range(0, 255)) - 128;
        end
        load_job(4, wi, xr, 0, 0, 0);
        run_job(4, 1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tpu_core.md
# tpu_core

Parametrised N×N output-stationary systolic matrix-multiply engine. Next generation of the Tiny Tapeout 2×2 TPU datapath. It byte-loads an N×N weight matrix W and an N×N input matrix X, computes C = X·W (or X·W^T), applies optional ReLU, and streams results out over a ready/valid port with backpressure. It sits behind the top-level pin wrapper, which maps `ui_in`/`uio_in`/`uo_out` onto its ports.

## Interface
- `N`, 2: array dimension; supported range 2..8.
- `DATA_W`, 8: operand width, signed two's complement.
- `ACC_W`, 16: accumulator width, signed. Must be ≥ 2·DATA_W.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `load_en`  in  1  qualifies `in_data`; one byte captured per cycle while high in IDLE/LOAD.
- `in_data`  in  DATA_W  load byte.
- `transpose`  in  1  use W^T; sampled on the COMPUTE entry edge.
- `activation`  in  1  ReLU enable; sampled on the COMPUTE entry edge.
- `out_data`  out  8  result byte.
- `out_valid`  out  1  `out_data` holds a valid transfer.
- `out_ready`  in  1  consumer accepts the transfer when `out_valid & out_ready`.
- `done`  out  1  one-cycle pulse after the last transfer is accepted.
- `busy`  out  1  high in COMPUTE and OUTPUT.

## Operation
- States: IDLE → LOAD → COMPUTE → OUTPUT → IDLE.
- IDLE/LOAD: each cycle with `load_en=1`, `in_data` is written at load address `a`, then `a` increments. Addresses 0..N²−1 hold W in row-major order. Addresses N²..2N²−1 hold X in row-major order.
- The first captured byte moves IDLE→LOAD.
- Dropping `load_en` mid-load pauses the load. The address holds and there is no timeout.
- On the capture edge of byte 2N²−1:
  - `a` returns to 0.
  - All accumulators clear.
  - `transpose` and `activation` are latched.
  - State becomes COMPUTE.
- COMPUTE: skewed feed. Row i of X enters the left edge delayed i cycles. Column j of W (row j when transposed) enters the top edge delayed j cycles. PE(i,j) performs `acc += x·w` at step t for k = t−i−j, where 0 ≤ k < N. Zeros are fed outside that window.
- Arithmetic: products are sign-extended to ACC_W. Accumulation wraps modulo 2^ACC_W.
- OUTPUT: elements C[i][j] are sent in row-major order. A transfer advances only on `out_valid & out_ready`.
- Default output reduction, per element:
  - ReLU first: negative becomes 0.
  - Then saturate to the signed 8-bit range [−128, 127].
  - One transfer per element, N² transfers total.
- `load_en` is ignored in COMPUTE and OUTPUT. Bytes presented then are discarded.
- Memory contents persist across jobs. A new job overwrites them fully.

## Timing
- Reset values: state IDLE, `a`=0, accumulators 0, memory 0, latched flags 0, `out_valid`=0, `done`=0, `busy`=0, `out_data`=0.
- Synchronous reset in any state, including mid-COMPUTE or mid-OUTPUT, aborts the job. The next edge shows reset values.
- COMPUTE lasts exactly 3N−2 cycles. For N=2 that is 4 cycles.
- `out_valid` rises on the first OUTPUT cycle: 3N−2 cycles after the last-byte capture edge.
- With `out_ready` held high, one transfer occurs per cycle.
- With `out_ready` low, `out_data` and `out_valid` hold stable.
- On acceptance of the final transfer, in the next cycle:
  - `out_valid`=0 and `done`=1 for exactly one cycle.
  - State is IDLE.
- A `load_en` byte in that same cycle is captured as address 0 of the next job.
- `busy` equals (state == COMPUTE || state == OUTPUT), registered with the state.

## Configuration
- `TPU_WIDE_OUT_EN` defined: no saturation. Each element is sent as the ACC_W result in bytes, least-significant first, after ReLU. That is ACC_W/8 transfers per element, and ACC_W must be a multiple of 8.
- Undefined: saturated 8-bit output as described in Operation.
- `done` timing is relative to the final transfer in both cases.

## Structure
- Package `tpu_pkg` holds:
  - state enum (`ST_IDLE`, `ST_LOAD`, `ST_COMPUTE`, `ST_OUTPUT`);
  - address-width function `clog2(2·N²)`;
  - signed saturate-to-8 function;
  - ReLU function.
- Sub-module `tpu_pe`: one MAC cell with registered right/down operand pass-through, an accumulator, and a synchronous clear. It is instantiated N×N via generate.
- Operand memory, skew registers, FSM and output mux live in `tpu_core`.

## Test plan
- N=2, W=[[1,2],[3,4]], X=[[5,6],[7,8]], transpose=0, ready high → 23,34,31,46; `out_valid` rises 4 cycles after the last byte; `done` pulses once.
- Same data, transpose=1 → 17,39,23,53.
- W=[[−1,0],[0,−1]], X as above: activation=0 → 0xFB,0xFA,0xF9,0xF8; activation=1 → 0,0,0,0.
- X and W all 127, N=2 → 127 ×4 by default. With `TPU_WIDE_OUT_EN` → 0x02,0x7E repeated 4 times (32258 = 0x7E02).
- Load with `load_en` gaps, then toggle `out_ready` randomly → identical result sequence, and `out_data` is stable while stalled.
- Assert `rst_n`=0 mid-OUTPUT → next cycle `out_valid`=0, `busy`=0. A following full job on N=4 with identity W returns X unchanged.
